// File: rtl/heichips25_project_mux.sv
// ============================================================================
// Module  : heichips25_project_mux
// Brief   : Run-time selectable N-slot tiny-project pin mux with drain/reset sequencing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module heichips25_project_mux #(
  parameter int N_PROJ       = 4,
  parameter int SEL_W        = (N_PROJ > 2) ? $clog2(N_PROJ) : 1,
  parameter int DEFAULT_PROJ = 0,
  parameter int DRAIN_CYCLES = 2,
  parameter int RST_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel_id,
  output logic                  sel_ready,
  output logic                  sel_err,
  output logic [SEL_W-1:0]      active_id,
  output logic                  busy,
  output logic [N_PROJ-1:0]     proj_ena,
  output logic [N_PROJ-1:0]     proj_rst_n,
  input  logic [8*N_PROJ-1:0]   proj_uo_out,
  input  logic [8*N_PROJ-1:0]   proj_uio_out,
  input  logic [8*N_PROJ-1:0]   proj_uio_oe,
  output logic [7:0]            uo_out,
  output logic [7:0]            uio_out,
  output logic [7:0]            uio_oe
);

  localparam int C_MAX_CNT = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int CNT_W     = (C_MAX_CNT > 1) ? $clog2(C_MAX_CNT + 1) : 1;

  localparam logic [CNT_W-1:0] C_DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [SEL_W:0]   C_N_LIMIT    = (SEL_W + 1)'(N_PROJ);
  localparam logic [SEL_W-1:0] C_DEFAULT_ID = SEL_W'(DEFAULT_PROJ);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    HOLD_RST = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  active_q, active_d;
  logic [SEL_W-1:0]  next_q, next_d;
  logic              err_q, err_d;

  logic              w_run;
  logic              w_pins_on;
  logic [N_PROJ-1:0] w_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HOLD_RST;
      cnt_q    <= '0;
      active_q <= C_DEFAULT_ID;
      next_q   <= C_DEFAULT_ID;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      next_q   <= next_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    next_d   = next_q;
    err_d    = err_q;
    case (state_q)
      RUN: begin
        if (sel_valid) begin
          if ({1'b0, sel_id} < C_N_LIMIT) begin
            next_d  = sel_id;
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Old slot keeps the pins (forced safe) until the hand-over to HOLD_RST.
        if (cnt_q == C_DRAIN_LAST) begin
          active_d = next_q;
          state_d  = HOLD_RST;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD_RST: begin
        if (cnt_q == C_RST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD_RST;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_run     = (state_q == RUN);
  assign w_pins_on = w_run & ena;
  assign w_onehot  = N_PROJ'(1) << active_q;

  assign sel_ready  = w_run;
  assign busy       = ~w_run;
  assign sel_err    = err_q;
  assign active_id  = active_q;
  assign proj_ena   = w_pins_on ? w_onehot : '0;
  assign proj_rst_n = (w_run || state_q == DRAIN) ? w_onehot : '0;

  // Explicit compare loop keeps the mux X-free for any active_q encoding.
  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    uio_oe  = 8'h00;
    for (int k = 0; k < N_PROJ; k++) begin
      if (w_pins_on && active_q == SEL_W'(k)) begin
        uo_out  = proj_uo_out[8*k +: 8];
        uio_out = proj_uio_out[8*k +: 8];
        uio_oe  = proj_uio_oe[8*k +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_heichips25_project_mux.sv
// ============================================================================
// Module  : tb_heichips25_project_mux
// Brief   : Scoreboard bench for two mux instances (4 slots and 3 slots).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_heichips25_project_mux;

  localparam int DR = 2;
  localparam int RC = 4;

  typedef struct {
    logic       rdy;
    logic       busy;
    logic       err;
    logic [1:0] act;
    logic [3:0] ena_v;
    logic [3:0] rstn;
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_id = 2'd0;
  logic [31:0] uo_bus = '0;
  logic [31:0] uio_bus = '0;
  logic [31:0] oe_bus = '0;

  logic       rdy4, err4, busy4, rdy3, err3, busy3;
  logic [1:0] act4, act3;
  logic [3:0] ena4, rstn4;
  logic [2:0] ena3, rstn3;
  logic [7:0] uo4, uio4, oe4, uo3, uio3, oe3;

  int n_err = 0;
  int n_chk = 0;

  int  left [2];
  int  cur  [2];
  int  pend [2];
  bit  err  [2];
  int  nproj [2] = '{4, 3};

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  heichips25_project_mux #(.N_PROJ(4)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena), .sel_valid(sel_valid), .sel_id(sel_id),
    .sel_ready(rdy4), .sel_err(err4), .active_id(act4), .busy(busy4),
    .proj_ena(ena4), .proj_rst_n(rstn4),
    .proj_uo_out(uo_bus), .proj_uio_out(uio_bus), .proj_uio_oe(oe_bus),
    .uo_out(uo4), .uio_out(uio4), .uio_oe(oe4)
  );

  heichips25_project_mux #(.N_PROJ(3)) u_dut3 (
    .clk(clk), .rst(rst), .ena(ena), .sel_valid(sel_valid), .sel_id(sel_id),
    .sel_ready(rdy3), .sel_err(err3), .active_id(act3), .busy(busy3),
    .proj_ena(ena3), .proj_rst_n(rstn3),
    .proj_uo_out(uo_bus[23:0]), .proj_uio_out(uio_bus[23:0]), .proj_uio_oe(oe_bus[23:0]),
    .uo_out(uo3), .uio_out(uio3), .uio_oe(oe3)
  );

  // Model: 'left' counts remaining busy cycles; DRAIN while left > RC, HOLD_RST while 1..RC.
  function automatic exp_t model_out(int m);
    exp_t e;
    bit   run = (left[m] == 0);
    e.rdy   = run;
    e.busy  = !run;
    e.err   = err[m];
    e.act   = 2'((left[m] > RC) ? cur[m] : pend[m]);
    e.ena_v = (run && ena) ? 4'(1 << cur[m]) : 4'd0;
    e.rstn  = (run || left[m] > RC) ? 4'(1 << cur[m]) : 4'd0;
    e.uo    = (run && ena) ? uo_bus[8*cur[m] +: 8]  : 8'd0;
    e.uio   = (run && ena) ? uio_bus[8*cur[m] +: 8] : 8'd0;
    e.oe    = (run && ena) ? oe_bus[8*cur[m] +: 8]  : 8'd0;
    return e;
  endfunction

  function automatic void model_reset(int m);
    left[m] = RC;
    cur[m]  = 0;
    pend[m] = 0;
    err[m]  = 1'b0;
  endfunction

  function automatic void model_edge(int m, bit v, int id);
    if (left[m] == 0) begin
      if (v) begin
        if (id < nproj[m]) begin
          pend[m] = id;
          left[m] = DR + RC;
        end else begin
          err[m] = 1'b1;
        end
      end
    end else begin
      left[m]--;
      if (left[m] <= RC) cur[m] = pend[m];
    end
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [7:0] act, input logic [7:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  task automatic step(input bit r, input bit en, input bit v, input logic [1:0] id);
    rst       = r;
    ena       = en;
    sel_valid = v;
    sel_id    = id;
    uo_bus    = $urandom;
    uio_bus   = $urandom;
    oe_bus    = $urandom;
    if (r) begin
      model_reset(0);
      model_reset(1);
    end
    q0.push_back(model_out(0));
    q1.push_back(model_out(1));
    @(posedge clk);
    if (!r) begin
      model_edge(0, v, int'(id));
      model_edge(1, v, int'(id));
    end
    #1;
  endtask

  int cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d4.sel_ready", cyc, {7'd0, rdy4},  {7'd0, e.rdy});
      chk("d4.busy",      cyc, {7'd0, busy4}, {7'd0, e.busy});
      chk("d4.sel_err",   cyc, {7'd0, err4},  {7'd0, e.err});
      chk("d4.active_id", cyc, {6'd0, act4},  {6'd0, e.act});
      chk("d4.proj_ena",  cyc, {4'd0, ena4},  {4'd0, e.ena_v});
      chk("d4.proj_rst_n", cyc, {4'd0, rstn4}, {4'd0, e.rstn});
      chk("d4.uo_out",    cyc, uo4,  e.uo);
      chk("d4.uio_out",   cyc, uio4, e.uio);
      chk("d4.uio_oe",    cyc, oe4,  e.oe);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d3.sel_ready", cyc, {7'd0, rdy3},  {7'd0, e.rdy});
      chk("d3.busy",      cyc, {7'd0, busy3}, {7'd0, e.busy});
      chk("d3.sel_err",   cyc, {7'd0, err3},  {7'd0, e.err});
      chk("d3.active_id", cyc, {6'd0, act3},  {6'd0, e.act});
      chk("d3.proj_ena",  cyc, {5'd0, ena3},  {4'd0, e.ena_v});
      chk("d3.proj_rst_n", cyc, {5'd0, rstn3}, {4'd0, e.rstn});
      chk("d3.uo_out",    cyc, uo3,  e.uo);
      chk("d3.uio_out",   cyc, uio3, e.uio);
      chk("d3.uio_oe",    cyc, oe3,  e.oe);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset, then default slot comes up after the reset hold.
    repeat (2) step(1'b1, 1'b1, 1'b0, 2'd0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 2'd0);
    // Switch to slot 2, then re-select slot 2 with valid held through busy.
    step(1'b0, 1'b1, 1'b1, 2'd2);
    repeat (8) step(1'b0, 1'b1, 1'b0, 2'd0);
    repeat (9) step(1'b0, 1'b1, 1'b1, 2'd2);
    repeat (3) step(1'b0, 1'b1, 1'b0, 2'd0);
    // Id 3: valid on the 4-slot instance, out of range on the 3-slot one.
    step(1'b0, 1'b1, 1'b1, 2'd3);
    repeat (8) step(1'b0, 1'b1, 1'b0, 2'd0);
    // Global enable low in RUN.
    repeat (4) step(1'b0, 1'b0, 1'b0, 2'd0);
    // Reset asserted mid-drain.
    step(1'b0, 1'b1, 1'b1, 2'd1);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    repeat (7) step(1'b0, 1'b1, 1'b0, 2'd0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
